// File: rtl/game_move_sequencer.sv
// ---------------------------------------------------------------------------
// game_move_sequencer
//
// Purpose:
//   Game-flow controller for a 2048 board. It turns one-cycle keyboard pulses
//   into move and spawn requests for the board datapath. It also runs the
//   win/lose check after every changed move, and keeps the score and the
//   count of changed moves.
//
// Ports:
//   clk, rst_n               system clock, synchronous active-low reset
//   key_left/up/down/right   one-cycle direction pulses
//   key_start                one-cycle pulse: start / new game
//   key_menu                 one-cycle pulse: back to menu
//   key_reset                one-cycle pulse: restart the game from any state
//   move_req / move_dir      move request (held until move_done) and its direction
//                            (0=left 1=up 2=down 3=right)
//   move_done                datapath finished the move (1-cycle pulse)
//   move_changed, merge_pts  move result, valid together with move_done
//   spawn_req / spawn_done   tile-spawn request (held until done) and its completion
//   has_2048, can_move       board status levels, used in CHECK
//   board_clr                one-cycle board clear pulse
//   state                    MENU=0 PLAY=1 MOVE=2 SPAWN=3 CHECK=4 WON=5 LOST=6 CLEAR=7
//   score                    saturating score
//   moves                    wrapping count of changed moves
//   busy                     high in MOVE, SPAWN, CHECK and CLEAR
//   timeout_err              sticky watchdog error, cleared by CLEAR
//
// Configuration:
//   GAME_PENDING_KEY_EN  when defined, the newest direction key received in
//                        MOVE/SPAWN/CHECK is held in a one-entry buffer. That
//                        key is replayed as soon as the sequencer is back in
//                        PLAY. When undefined, those keys are dropped.
// ---------------------------------------------------------------------------
module game_move_sequencer #(
    parameter int SCORE_W = 20,
    parameter int MOVES_W = 16,
    parameter int PTS_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_left,
    input  logic               key_up,
    input  logic               key_down,
    input  logic               key_right,
    input  logic               key_start,
    input  logic               key_menu,
    input  logic               key_reset,
    output logic               move_req,
    output logic [1:0]         move_dir,
    input  logic               move_done,
    input  logic               move_changed,
    input  logic [PTS_W-1:0]   merge_pts,
    output logic               spawn_req,
    input  logic               spawn_done,
    input  logic               has_2048,
    input  logic               can_move,
    output logic               board_clr,
    output logic [2:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [MOVES_W-1:0] moves,
    output logic               busy,
    output logic               timeout_err
);

    localparam logic [2:0] ST_MENU  = 3'd0;
    localparam logic [2:0] ST_PLAY  = 3'd1;
    localparam logic [2:0] ST_MOVE  = 3'd2;
    localparam logic [2:0] ST_SPAWN = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_WON   = 3'd5;
    localparam logic [2:0] ST_LOST  = 3'd6;
    localparam logic [2:0] ST_CLEAR = 3'd7;

    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int SUM_W = ((SCORE_W > PTS_W) ? SCORE_W : PTS_W) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [2:0]         state_q,       state_d;
    logic [1:0]         dir_q,         dir_d;
    logic [SCORE_W-1:0] score_q,       score_d;
    logic [MOVES_W-1:0] moves_q,       moves_d;
    logic [1:0]         spawn_cnt_q,   spawn_cnt_d;
    logic [WD_W-1:0]    wdog_q,        wdog_d;
    logic               timeout_err_q, timeout_err_d;
`ifdef GAME_PENDING_KEY_EN
    logic               pend_valid_q,  pend_valid_d;
    logic [1:0]         pend_dir_q,    pend_dir_d;
`endif

    logic               dir_key;
    logic [1:0]         dir_sel;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;

    // Direction key decode, with the priority left > up > down > right.
    always_comb begin
        dir_key = key_left | key_up | key_down | key_right;
        if (key_left)      dir_sel = 2'd0;
        else if (key_up)   dir_sel = 2'd1;
        else if (key_down) dir_sel = 2'd2;
        else               dir_sel = 2'd3;
    end

    // Saturating add. The extra carry bit tells us when the sum overflowed the score width.
    always_comb begin
        score_sum = SUM_W'(score_q) + SUM_W'(merge_pts);
        score_sat = (|score_sum[SUM_W-1:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];
    end

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can infer a latch.
        state_d       = state_q;
        dir_d         = dir_q;
        score_d       = score_q;
        moves_d       = moves_q;
        spawn_cnt_d   = spawn_cnt_q;
        timeout_err_d = timeout_err_q;
        wdog_d        = '0;

        if (key_reset) begin
            state_d = ST_CLEAR;
        end else begin
            case (state_q)
                ST_MENU: begin
                    if (key_start) state_d = ST_CLEAR;
                end
                ST_CLEAR: begin
                    score_d       = '0;
                    moves_d       = '0;
                    timeout_err_d = 1'b0;
                    spawn_cnt_d   = 2'd2;
                    state_d       = ST_SPAWN;
                end
                ST_PLAY: begin
                    if (key_menu) begin
                        state_d = ST_MENU;
`ifdef GAME_PENDING_KEY_EN
                    end else if (pend_valid_q) begin
                        state_d = ST_MOVE;
                        dir_d   = pend_dir_q;
`endif
                    end else if (dir_key) begin
                        state_d = ST_MOVE;
                        dir_d   = dir_sel;
                    end
                end
                ST_MOVE: begin
                    // A done that arrives on the last watchdog cycle still counts as a completion.
                    if (move_done) begin
                        score_d = score_sat;
                        if (move_changed) begin
                            moves_d     = moves_q + MOVES_W'(1);
                            spawn_cnt_d = 2'd1;
                            state_d     = ST_SPAWN;
                        end else begin
                            state_d = ST_PLAY;
                        end
                    end else if (wdog_q == WD_LAST) begin
                        timeout_err_d = 1'b1;
                        state_d       = ST_MENU;
                    end else begin
                        wdog_d = wdog_q + WD_W'(1);
                    end
                end
                ST_SPAWN: begin
                    // Each done starts a fresh watchdog window for the next spawn, if there is one.
                    if (spawn_done) begin
                        spawn_cnt_d = spawn_cnt_q - 2'd1;
                        if (spawn_cnt_q <= 2'd1) begin
                            spawn_cnt_d = '0;
                            state_d     = ST_CHECK;
                        end
                    end else if (wdog_q == WD_LAST) begin
                        timeout_err_d = 1'b1;
                        state_d       = ST_MENU;
                    end else begin
                        wdog_d = wdog_q + WD_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (has_2048)       state_d = ST_WON;
                    else if (!can_move) state_d = ST_LOST;
                    else                state_d = ST_PLAY;
                end
                ST_WON, ST_LOST: begin
                    if (key_menu)       state_d = ST_MENU;
                    else if (key_start) state_d = ST_CLEAR;
                end
                default: state_d = ST_MENU;
            endcase
        end

`ifdef GAME_PENDING_KEY_EN
        pend_valid_d = pend_valid_q;
        pend_dir_d   = pend_dir_q;
        case (state_q)
            ST_MOVE, ST_SPAWN, ST_CHECK: begin
                // The newest key wins. A key that arrives together with a restart is not captured.
                if (dir_key && !key_reset) begin
                    pend_valid_d = 1'b1;
                    pend_dir_d   = dir_sel;
                end
            end
            ST_PLAY: begin
                if (state_d == ST_MOVE) pend_valid_d = 1'b0;
            end
            default: pend_valid_d = 1'b0;
        endcase
`endif
    end

    // NOTE: reset is synchronous, so it is sampled only on the clock edge, like any other input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q       <= ST_MENU;
            dir_q         <= '0;
            score_q       <= '0;
            moves_q       <= '0;
            spawn_cnt_q   <= '0;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
`ifdef GAME_PENDING_KEY_EN
            pend_valid_q  <= 1'b0;
            pend_dir_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            score_q       <= score_d;
            moves_q       <= moves_d;
            spawn_cnt_q   <= spawn_cnt_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
`ifdef GAME_PENDING_KEY_EN
            pend_valid_q  <= pend_valid_d;
            pend_dir_q    <= pend_dir_d;
`endif
        end
    end

    // The requests are decoded from the registered state. They rise on entry to MOVE/SPAWN and
    // drop in the same cycle the state leaves it, whether by done, restart or timeout.
    assign move_req    = (state_q == ST_MOVE);
    assign spawn_req   = (state_q == ST_SPAWN);
    assign board_clr   = (state_q == ST_CLEAR);
    assign busy        = (state_q == ST_MOVE) || (state_q == ST_SPAWN) ||
                         (state_q == ST_CHECK) || (state_q == ST_CLEAR);
    assign move_dir    = dir_q;
    assign state       = state_q;
    assign score       = score_q;
    assign moves       = moves_q;
    assign timeout_err = timeout_err_q;

endmodule
